// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester and UART-side signal bundle for uart_tx_arbiter.
//            i_lock exists only when UART_ARB_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int c_GW = $clog2(NREQ);

  logic [NREQ-1:0]    i_req;
  logic [NREQ*DW-1:0] i_data;
`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0]    i_lock;
`endif
  logic [NREQ-1:0]    o_ack;
  logic               o_uart_write;
  logic [DW-1:0]      o_uart_data;
  logic               i_uart_busy;
  logic [c_GW-1:0]    o_grant;
  logic               o_active;

  modport slave (
    input  i_req,
    input  i_data,
`ifdef UART_ARB_LOCK_EN
    input  i_lock,
`endif
    input  i_uart_busy,
    output o_ack,
    output o_uart_write,
    output o_uart_data,
    output o_grant,
    output o_active
  );

  modport master (
    output i_req,
    output i_data,
`ifdef UART_ARB_LOCK_EN
    output i_lock,
`endif
    output i_uart_busy,
    input  o_ack,
    input  o_uart_write,
    input  o_uart_data,
    input  o_grant,
    input  o_active
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin scheduler sharing one uart_tx between NREQ byte
//            producers. Optional grant lock via macro UART_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int c_GW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_GW-1:0] r_ptr;
  logic [c_GW-1:0] r_grant;
  logic [NREQ-1:0] r_ack;
  logic            r_write;
  logic [DW-1:0]   r_data;
  logic            r_active;
  logic            r_tmo;
`ifdef UART_ARB_LOCK_EN
  logic            r_last_vld;
`endif

  logic            w_rr_found;
  logic [c_GW-1:0] w_rr_idx;
  logic            w_go;
  logic [c_GW-1:0] w_win;
  logic [c_GW-1:0] w_next_ptr;
  logic [NREQ-1:0] w_win_onehot;

  function automatic logic [c_GW-1:0] f_wrap(input int v);
    f_wrap = c_GW'(v % NREQ);
  endfunction

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_rr_found && bus.i_req[f_wrap(int'(r_ptr) + i)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = f_wrap(int'(r_ptr) + i);
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic w_locked;
  // A locked previous winner blocks everyone else, even with no request.
  assign w_locked = r_last_vld && bus.i_lock[r_grant];
  assign w_go     = !bus.i_uart_busy && (w_locked ? bus.i_req[r_grant] : w_rr_found);
  assign w_win    = w_locked ? r_grant : w_rr_idx;
`else
  assign w_go     = !bus.i_uart_busy && w_rr_found;
  assign w_win    = w_rr_idx;
`endif

  assign w_next_ptr   = (r_grant == c_GW'(NREQ - 1)) ? '0 : r_grant + c_GW'(1);
  assign w_win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_write    <= 1'b0;
      r_data     <= '0;
      r_active   <= 1'b0;
      r_tmo      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      r_last_vld <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_grant  <= w_win;
            r_data   <= bus.i_data[int'(w_win) * DW +: DW];
            r_ack    <= w_win_onehot;
            r_write  <= 1'b1;
            r_active <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_write <= 1'b0;
          r_ack   <= '0;
          r_tmo   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
          r_last_vld <= 1'b1;
          if (!bus.i_lock[r_grant]) begin
            r_ptr <= w_next_ptr;
          end
`else
          r_ptr <= w_next_ptr;
`endif
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A UART that never raises busy would otherwise stall us forever.
          if (bus.i_uart_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_tmo) begin
            r_active <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_tmo <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.i_uart_busy) begin
            r_active <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_active <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ack        = r_ack;
  assign bus.o_uart_write = r_write;
  assign bus.o_uart_data  = r_data;
  assign bus.o_grant      = r_grant;
  assign bus.o_active     = r_active;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter with a simple UART busy
//            model and an in-order expected-grant scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] dat;
  } exp_t;

  typedef struct {
    int         tgt[4];
    logic [7:0] dat[4];
    int         hold;
    bit         ign;
    int         nexp;
    int         exp[6];
  } vec_t;

  int         tgt[NREQ];
  int         ackcnt[NREQ];
  logic [7:0] dat[NREQ];
  int         hold     = 1;
  bit         ign      = 1'b0;
  bit         ext_busy = 1'b0;
  logic       mbusy;
  int         mcnt;
  int         cyc = 0;
  exp_t       q[$];
  int         n_seen = 0;
  int         nfall  = 0;
  int         wcyc[16];
  int         falls[16];
  int         checks = 0;
  int         errors = 0;
`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0] lock = '0;
  assign bus.i_lock = lock;
`endif

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      bus.i_req[k]             = (ackcnt[k] < tgt[k]);
      bus.i_data[k*DW +: DW]   = dat[k];
    end
  end
  assign bus.i_uart_busy = mbusy | ext_busy;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy one cycle after the write, held for 'hold' cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
    end else if (bus.o_uart_write && !ign) begin
      mbusy <= 1'b1;
      mcnt  <= hold;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt  <= 0;
      mbusy <= 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic pw = 1'b0;
    logic pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_seen = 0;
        nfall  = 0;
        pw     = 1'b0;
        pb     = 1'b0;
        for (int k = 0; k < NREQ; k++) ackcnt[k] = 0;
        chk("rst_write",  int'(bus.o_uart_write), 0);
        chk("rst_ack",    int'(bus.o_ack),        0);
        chk("rst_grant",  int'(bus.o_grant),      0);
        chk("rst_data",   int'(bus.o_uart_data),  0);
        chk("rst_active", int'(bus.o_active),     0);
      end else begin
        if (bus.o_uart_write) begin
          chk("no_back_to_back", int'(pw), 0);
          if (n_seen < q.size()) begin
            chk("byte",  int'(bus.o_uart_data), int'(q[n_seen].dat));
            chk("ack",   int'(bus.o_ack),       1 << q[n_seen].idx);
            chk("grant", int'(bus.o_grant),     int'(q[n_seen].idx));
          end else begin
            chk("unexpected_write", n_seen, q.size());
          end
          if (n_seen < 16) wcyc[n_seen] = cyc;
          n_seen++;
          for (int k = 0; k < NREQ; k++) if (bus.o_ack[k]) ackcnt[k]++;
        end else if (bus.o_ack != '0) begin
          chk("ack_without_write", int'(bus.o_ack), 0);
        end
        if (pb && !bus.i_uart_busy) begin
          if (nfall < 16) falls[nfall] = cyc;
          nfall++;
        end
        pw = bus.o_uart_write;
        pb = bus.i_uart_busy;
      end
    end
  endtask

  task automatic push(input int idx);
    exp_t e;
    e.idx = 2'(idx);
    e.dat = dat[idx];
    q.push_back(e);
  endtask

  task automatic do_reset();
    for (int k = 0; k < NREQ; k++) tgt[k] = 0;
    ign      = 1'b0;
    ext_busy = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock = '0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    q.delete();
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      #1;
      done = (n_seen >= q.size()) && !bus.o_active && !bus.i_uart_busy;
      for (int k = 0; k < NREQ; k++) if (ackcnt[k] < tgt[k]) done = 1'b0;
      n++;
    end
    chk({nm, "_done"},  int'(done), 1);
    chk({nm, "_count"}, n_seen, q.size());
  endtask

  task automatic wait_writes(input string nm, input int cnt, input int budget);
    int n = 0;
    while (n_seen < cnt && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({nm, "_writes"}, n_seen >= cnt ? cnt : n_seen, cnt);
  endtask

  vec_t vec[6];

  initial begin
    int rq;
    vec[0] = '{tgt:'{0,0,1,0}, dat:'{8'h00,8'h00,8'hA5,8'h00}, hold:10, ign:0, nexp:1, exp:'{2,0,0,0,0,0}};
    vec[1] = '{tgt:'{2,1,1,1}, dat:'{8'h10,8'h11,8'h12,8'h13}, hold:4,  ign:0, nexp:5, exp:'{0,1,2,3,0,0}};
    vec[2] = '{tgt:'{1,0,1,0}, dat:'{8'h3C,8'h00,8'hC3,8'h00}, hold:3,  ign:0, nexp:2, exp:'{0,2,0,0,0,0}};
    vec[3] = '{tgt:'{0,1,0,1}, dat:'{8'h00,8'h5A,8'h00,8'hA7}, hold:1,  ign:1, nexp:2, exp:'{1,3,0,0,0,0}};
    vec[4] = '{tgt:'{1,0,0,2}, dat:'{8'hE1,8'h00,8'h00,8'h7E}, hold:2,  ign:0, nexp:3, exp:'{0,3,3,0,0,0}};
    vec[5] = '{tgt:'{0,2,1,0}, dat:'{8'h00,8'hB1,8'hB2,8'h00}, hold:1,  ign:0, nexp:3, exp:'{1,2,1,0,0,0}};

    for (int k = 0; k < NREQ; k++) begin
      tgt[k]    = 0;
      ackcnt[k] = 0;
      dat[k]    = 8'h00;
    end
    fork
      monitor();
    join_none

    // Reset held with every requester asserted.
    for (int k = 0; k < NREQ; k++) begin
      dat[k] = 8'h10 + 8'(k);
      tgt[k] = 1;
      push(k);
    end
    hold = 2;
    repeat (5) @(posedge clk);
    chk("rst_no_write", n_seen, 0);
    #1 rst_n = 1'b1;
    wait_idle("reset_release", 200);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int k = 0; k < NREQ; k++) dat[k] = vec[i].dat[k];
      hold = vec[i].hold;
      ign  = vec[i].ign;
      for (int j = 0; j < vec[i].nexp; j++) push(vec[i].exp[j]);
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) tgt[k] = vec[i].tgt[k];
      wait_idle($sformatf("vec%0d", i), 300);
    end

    // Request-to-write and busy-fall-to-write latency.
    do_reset();
    hold   = 10;
    dat[2] = 8'hA5;
    push(2);
    push(2);
    @(posedge clk);
    #1;
    tgt[2] = 2;
    rq     = cyc;
    wait_writes("lat", 1, 20);
    chk("lat_req_to_write", wcyc[0] - rq, 1);
    wait_idle("lat", 100);
    chk("lat_busy_fall_to_write", wcyc[1] - falls[0], 2);

    // UART drops the write: arbiter gives up and serves the next requester.
    do_reset();
    ign    = 1'b1;
    dat[1] = 8'h5A;
    dat[3] = 8'hA7;
    push(1);
    push(3);
    @(posedge clk);
    #1;
    tgt[1] = 1;
    tgt[3] = 1;
    wait_writes("tmo", 1, 20);
    while (cyc < wcyc[0] + 2) @(negedge clk);
    chk("tmo_active_wait", int'(bus.o_active), 1);
    @(negedge clk);
    chk("tmo_idle_after3", int'(bus.o_active), 0);
    wait_idle("tmo", 100);
    chk("tmo_regrant_gap", wcyc[1] - wcyc[0], 4);

    // External writer holds busy in IDLE.
    do_reset();
    ext_busy = 1'b1;
    hold     = 3;
    dat[3]   = 8'h77;
    push(3);
    @(posedge clk);
    #1;
    tgt[3] = 1;
    repeat (6) @(negedge clk);
    chk("ext_busy_no_write", n_seen, 0);
    chk("ext_busy_idle", int'(bus.o_active), 0);
    ext_busy = 1'b0;
    wait_idle("ext_busy", 100);

    // Asynchronous reset during WAIT_DONE.
    do_reset();
    hold   = 10;
    dat[2] = 8'h99;
    push(2);
    @(posedge clk);
    #1;
    tgt[2] = 1;
    wait_writes("mid", 1, 20);
    while (cyc < wcyc[0] + 3) begin
      @(posedge clk);
      #1;
    end
    chk("mid_active_before", int'(bus.o_active), 1);
    #2;
    tgt[2] = 0;
    rst_n  = 1'b0;
    #1;
    chk("mid_active",  int'(bus.o_active),     0);
    chk("mid_write",   int'(bus.o_uart_write), 0);
    chk("mid_ack",     int'(bus.o_ack),        0);
    chk("mid_grant",   int'(bus.o_grant),      0);
    chk("mid_data",    int'(bus.o_uart_data),  0);
    repeat (3) @(posedge clk);
    q.delete();
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("mid_no_ack_after", n_seen, 0);

`ifdef UART_ARB_LOCK_EN
    // Locked requester 1 keeps the line for three bytes.
    do_reset();
    hold   = 2;
    dat[1] = 8'hC1;
    dat[2] = 8'hC2;
    lock   = 4'b0010;
    push(1);
    push(1);
    push(1);
    push(2);
    @(posedge clk);
    #1;
    tgt[1] = 3;
    tgt[2] = 1;
    wait_writes("lock", 3, 200);
    repeat (10) @(negedge clk);
    #1;
    chk("lock_holds_off_other", n_seen, 3);
    lock = '0;
    wait_idle("lock", 100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` transmitter between `NREQ` byte producers. Each producer raises a request with a byte. The arbiter picks one requester, issues a single-cycle write to the UART, acknowledges the winner, and tracks the UART busy flag until the byte is on the wire. It sits between the data sources (for example `input_data` instances) and `uart_tx`, and replaces the direct `transmit = !uart_busy` coupling.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, range 2..8.
- `DW`, default 8: byte width, matching `uart_tx` `i_data`.

Ports:
- `i_clk`, input, 1: system clock. This is the only clock.
- `i_rst_n`, input, 1: reset, asynchronous and active-low.
- `i_req`, input, `NREQ`: per-requester request level. It stays high until that requester's `o_ack`.
- `i_data`, input, `NREQ*DW`: per-requester byte. Requester k uses bits `[k*DW +: DW]` and holds them stable while `i_req[k]` is high.
- `i_lock`, input, `NREQ`: per-requester grant lock. Present only with `UART_ARB_LOCK_EN`.
- `o_ack`, output, `NREQ`: one-hot, one-cycle pulse when the requester's byte is issued.
- `o_uart_write`, output, 1: drives `uart_tx` `i_write`.
- `o_uart_data`, output, `DW`: drives `uart_tx` `i_data`.
- `i_uart_busy`, input, 1: from `uart_tx` `o_busy`.
- `o_grant`, output, `$clog2(NREQ)`: index of the current or last granted requester.
- `o_active`, output, 1: high in every state except `IDLE`.

## Operation
State machine with four states: `IDLE`, `ISSUE`, `WAIT_BUSY`, `WAIT_DONE`.

- `IDLE`
  - Condition: `|i_req` and `!i_uart_busy`.
  - Action: select the winner by round-robin and register the winner's index into `o_grant` and its byte into `o_uart_data`.
  - Transition: go to `ISSUE`. Otherwise stay in `IDLE`.
- `ISSUE` (exactly one cycle)
  - `o_uart_write=1`.
  - `o_ack[o_grant]=1`.
  - Round-robin pointer becomes `(o_grant+1) mod NREQ`.
  - Transition: go to `WAIT_BUSY`.
- `WAIT_BUSY`
  - Wait for `i_uart_busy=1`, then go to `WAIT_DONE`.
  - Timeout: if busy has not risen after 2 cycles in this state, return to `IDLE`. This covers a UART that drops the write.
- `WAIT_DONE`
  - Wait for `i_uart_busy=0`, then go to `IDLE`.
- Round-robin rule: search starts at the pointer and increments modulo `NREQ`; the first set `i_req` bit wins. The pointer resets to 0.
- A requester whose `i_req` drops before its `o_ack` is simply not selected. A byte already latched in `IDLE` is still issued and acked.
- `o_uart_data` holds the last issued byte until the next grant.

## Timing
Reset values (asynchronous, applied while `i_rst_n=0`):
- State = `IDLE`, pointer = 0.
- `o_ack`=0, `o_uart_write`=0, `o_uart_data`=0, `o_grant`=0, `o_active`=0.

Latency:
- `i_req[k]` rising in cycle N, while in `IDLE` with busy low, gives `o_uart_write` and `o_ack[k]` high in cycle N+1.
- After `i_uart_busy` falls in cycle M, with `i_req` still pending, the next `o_uart_write` occurs in cycle M+2.

Boundary conditions:
- Simultaneous requests are served in round-robin order. With all `NREQ` requesting continuously, each gets exactly one byte per `NREQ` grants.
- If `i_uart_busy` is high in `IDLE` (an external writer), the arbiter does not grant.
- Reset asserted mid-transfer returns to `IDLE` immediately with no ack. The UART's own reset handles any frame in flight.
- `o_uart_write` is never high in two consecutive cycles.
- `o_ack` is never multi-hot.

## Configuration
Macro: `UART_ARB_LOCK_EN`.

- Defined:
  - The `i_lock` port exists.
  - In `IDLE`, if the previous winner `g` has `i_lock[g]=1`, it is re-granted ahead of round-robin when its `i_req[g]=1`. If it has no request, the arbiter waits and grants no one else until `i_lock[g]` drops or `i_req[g]` rises.
  - The pointer does not advance while the lock is held.
  - This keeps multi-byte messages contiguous on the line.
- Undefined:
  - No `i_lock` port.
  - Pure round-robin, re-arbitrated for every byte.

## Test plan
- Reset: hold `i_rst_n=0` with `i_req=4'b1111`. Response: all outputs are 0 and no write occurs. Release reset, then the first grant goes to requester 0 (`o_grant=0`).
- Single requester: `i_req=4'b0100`, `i_data[23:16]=8'hA5`, UART model raises busy 1 cycle after the write and holds it 10 cycles. Response: one write with `o_uart_data=8'hA5` and `o_ack=4'b0100` one cycle after the request; the next write comes 2 cycles after busy falls.
- Fairness: all four request continuously with bytes 8'h10, 8'h11, 8'h12, 8'h13. Response: the UART sees the sequence 10, 11, 12, 13, 10 and each ack is one-hot.
- Busy timeout: UART model ignores the write (busy stays 0). Response: the arbiter returns to `IDLE` 3 cycles after `ISSUE` and re-grants the next pending requester.
- Mid-transfer reset: assert `i_rst_n=0` during `WAIT_DONE`. Response: the state goes to `IDLE` asynchronously, `o_active=0`, and no ack is emitted.
- With `UART_ARB_LOCK_EN`: requester 1 holds `i_lock[1]` and sends 3 bytes while requester 2 is requesting. Response: three consecutive grants go to 1; requester 2 is granted only after `i_lock[1]` drops.
